// File: rtl/mem_bus_arbiter.sv
// Two-port memory bus arbiter: shares one fixed-latency memory port between the CPU (C) and a DMA/debug master (D).
// Round-robin between ports, with an optional D burst lock capped at MAX_BURST consecutive grants while C waits.
module mem_bus_arbiter #(
   parameter int M           = 16,
   parameter int N           = 32,
   parameter int MEM_LATENCY = 1,
   parameter int MAX_BURST   = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         c_req,
   input  logic         c_we,
   input  logic [N-1:0] c_addr,
   input  logic [M-1:0] c_wdata,
   output logic [M-1:0] c_rdata,
   output logic         c_ack,
   input  logic         d_req,
   input  logic         d_we,
   input  logic [N-1:0] d_addr,
   input  logic [M-1:0] d_wdata,
   input  logic         d_lock,
   output logic [M-1:0] d_rdata,
   output logic         d_ack,
   output logic [N-1:0] mem_addr,
   output logic [M-1:0] mem_wdata,
   output logic         mem_re,
   output logic         mem_we,
   input  logic [M-1:0] mem_rdata,
   output logic         owner
);

   localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam int BW = $clog2(MAX_BURST + 1);

   typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt;
   logic [BW-1:0] burst_cnt;
   logic          we_lat;
   logic          last_owner;
   logic          lock_flag;
   logic          any_req;
   logic          lock_hold;
   logic          grant_d;

   assign any_req   = c_req | d_req;
   // D keeps the bus only if its previous ack asked for it and the burst budget is not spent
   assign lock_hold = last_owner & lock_flag & (burst_cnt < BW'(MAX_BURST));

   always_comb begin
      grant_d = d_req;
      if (c_req && d_req)
         grant_d = lock_hold ? 1'b1 : ~last_owner;
   end

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_req) state_nxt = ACCESS;
         ACCESS:  if (cnt == '0) state_nxt = ACK;
         ACK:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // datapath: grant capture, access counter, read capture, fairness bookkeeping
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         burst_cnt  <= '0;
         we_lat     <= 1'b0;
         owner      <= 1'b0;
         last_owner <= 1'b1;
         lock_flag  <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         c_rdata    <= '0;
         d_rdata    <= '0;
      end else begin
         case (state)
            IDLE: if (any_req) begin
               owner     <= grant_d;
               mem_addr  <= grant_d ? d_addr  : c_addr;
               mem_wdata <= grant_d ? d_wdata : c_wdata;
               we_lat    <= grant_d ? d_we    : c_we;
               cnt       <= CW'(MEM_LATENCY - 1);
               if (!grant_d) burst_cnt <= '0;
            end
            ACCESS: begin
               if (cnt == '0) begin
                  if (!we_lat) begin
                     if (owner) d_rdata <= mem_rdata;
                     else       c_rdata <= mem_rdata;
                  end
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            ACK: begin
               last_owner <= owner;
               lock_flag  <= owner & d_lock;
               if (owner && d_lock)
                  burst_cnt <= (burst_cnt == BW'(MAX_BURST)) ? burst_cnt : burst_cnt + BW'(1);
               else
                  burst_cnt <= '0;
            end
            default: ;
         endcase
      end
   end

   // outputs decoded from state
   always_comb begin
      mem_re = 1'b0;
      mem_we = 1'b0;
      c_ack  = 1'b0;
      d_ack  = 1'b0;
      case (state)
         ACCESS: begin
            mem_re = ~we_lat;
            mem_we = we_lat;
         end
         ACK: begin
            c_ack = ~owner;
            d_ack = owner;
         end
         default: ;
      endcase
   end

endmodule
